jesd204_tx_ctrl_64b: RTL and testbench
======================================

JESD204_TX_CTRL_64B -- requirements
Module: jesd204_tx_ctrl_64b

Interface
REQ-001 SHALL have parameter EMB_WIDTH, default 8: width of the extended-multiblock length config.
REQ-002 SHALL have port clk  in  1  sole clock; all logic posedge clk.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port sysref  in  1  SYSREF already synchronous to clk, level; rising edge is the event.
REQ-005 SHALL have port cfg_mb_per_emb  in  EMB_WIDTH  multiblocks per extended multiblock minus 1 (E-1).
REQ-006 SHALL have port cfg_lmc_offset  in  5  beat-counter value loaded on a SYSREF edge.
REQ-007 SHALL have port cfg_sysref_oneshot  in  1  1: only first SYSREF edge realigns.
REQ-008 SHALL have port cfg_sysref_disable  in  1  1: skip SYSREF wait, free-run from 0.
REQ-009 SHALL have port tx_ready  out  1  link data phase; drives lane tx_ready.
REQ-010 SHALL have port lmc_edge  out  1  first beat of each 32-beat multiblock.
REQ-011 SHALL have port lmc_quarter_edge  out  1  first beat of each 8-beat quarter.
REQ-012 SHALL have port eoemb  out  1  high for every beat of the last multiblock of an extended multiblock.
REQ-013 SHALL have port status_state  out  2  0 RESET, 1 WAIT_SYSREF, 2 START, 3 DATA.
REQ-014 SHALL have port event_sysref_edge  out  1  one-cycle pulse per detected SYSREF rising edge.
REQ-015 SHALL have port event_sysref_alignment_error  out  1  one-cycle pulse on misaligned SYSREF.
REQ-016 Config inputs SHALL be treated as static outside reset; behaviour on change while running is undefined.

Function
REQ-017 beat_cnt (5 bit) SHALL increment by 1 each cycle, wrapping 31->0; mb_cnt (EMB_WIDTH) SHALL increment when beat_cnt wraps, wrapping cfg_mb_per_emb->0.
REQ-018 lmc_edge SHALL be combinational (beat_cnt==0); lmc_quarter_edge SHALL be (beat_cnt[2:0]==0); eoemb SHALL be (mb_cnt==cfg_mb_per_emb); all three forced 0 in RESET and WAIT_SYSREF.
REQ-019 SYSREF edge SHALL be sysref & ~sysref_d, sysref_d registered, cleared by reset; event_sysref_edge SHALL be registered (1-cycle latency) and pulse in every state except RESET.
REQ-020 On a SYSREF edge in cycle T, if realignment is permitted, beat_cnt SHALL equal cfg_lmc_offset and mb_cnt 0 in cycle T+1, replacing the natural increment.
REQ-021 Realignment SHALL be permitted unless cfg_sysref_oneshot=1 and a SYSREF edge has already been captured since reset.
REQ-022 Once aligned (a SYSREF captured, or cfg_sysref_disable=1), a SYSREF edge whose natural next (beat_cnt, mb_cnt) differs from (cfg_lmc_offset, 0) SHALL pulse event_sysref_alignment_error one cycle later; the edge still realigns if permitted.
REQ-023 First captured SYSREF SHALL never flag an error.
REQ-024 FSM RESET->WAIT_SYSREF on the first cycle after reset deasserts; RESET->START instead if cfg_sysref_disable=1, with counters starting at 0.
REQ-025 WAIT_SYSREF->START on the clock edge a SYSREF edge is captured; counters free-run meanwhile but outputs stay masked.
REQ-026 START->DATA at the edge where beat_cnt==31 and mb_cnt==cfg_mb_per_emb (natural wrap, no SYSREF in same cycle), so the first DATA cycle has lmc_edge=1, mb_cnt=0.
REQ-027 tx_ready SHALL equal (state==DATA); DATA SHALL be left only by reset; realignment or alignment error SHALL NOT drop tx_ready.
REQ-028 SYSREF edge coinciding with the START->DATA condition SHALL take priority: realign, remain in START.
REQ-029 cfg_mb_per_emb=0 SHALL give eoemb constantly high once unmasked and mb_cnt stuck at 0.

Reset
REQ-030 reset SHALL, at the next clock edge, set state RESET, beat_cnt=0, mb_cnt=0, sysref_d=0, captured flag=0, and all outputs 0, including when asserted mid-DATA.
REQ-031 reset SHALL dominate any same-cycle SYSREF edge; reset held N cycles SHALL keep all outputs 0 for those cycles.

Verification
REQ-032 cfg_sysref_disable=1, E-1=3: release reset -> START, tx_ready high 128 cycles later with lmc_edge=1; eoemb high beats 96..127 of each 128-beat period.
REQ-033 offset=5, SYSREF edge at cycle T in WAIT_SYSREF -> beat_cnt=5 at T+1, event_sysref_edge at T+1, no error; lmc_edge first at T+28.
REQ-034 Periodic SYSREF every 128 cycles consistent with offset, oneshot=0 -> no error pulses, tx_ready stays 1.
REQ-035 Aligned in DATA, inject SYSREF 3 cycles early, oneshot=0 -> one error pulse, counters realigned, tx_ready stays 1; same with oneshot=1 -> error pulse, counters not moved.
REQ-036 Assert reset for 1 cycle mid-DATA with SYSREF high same cycle -> all outputs 0 next cycle, state WAIT_SYSREF after release, no event pulses.

Source files
------------

// File: rtl/jesd204_tx_ctrl_64b.sv
// JESD204 transmit link controller for a 64b datapath: local multiframe/extended-multiblock
// counters, SYSREF alignment and the RESET/WAIT_SYSREF/START/DATA link state machine.
module jesd204_tx_ctrl_64b #(
    parameter int EMB_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sysref,
    input  logic [EMB_WIDTH-1:0] cfg_mb_per_emb,
    input  logic [4:0]           cfg_lmc_offset,
    input  logic                 cfg_sysref_oneshot,
    input  logic                 cfg_sysref_disable,
    output logic                 tx_ready,
    output logic                 lmc_edge,
    output logic                 lmc_quarter_edge,
    output logic                 eoemb,
    output logic [1:0]           status_state,
    output logic                 event_sysref_edge,
    output logic                 event_sysref_alignment_error
);

    typedef enum logic [1:0] {
        ST_RESET       = 2'd0,
        ST_WAIT_SYSREF = 2'd1,
        ST_START       = 2'd2,
        ST_DATA        = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           beat_cnt, beat_nat, beat_d;
    logic [EMB_WIDTH-1:0] mb_cnt, mb_nat, mb_d;
    logic                 sysref_d;
    logic                 captured;
    logic                 sysref_edge;
    logic                 edge_live;
    logic                 realign;
    logic                 align_err;
    logic                 unmasked;

    // Edges seen while the FSM sits in RESET are ignored entirely: no event, no capture.
    assign sysref_edge = sysref & ~sysref_d;
    assign edge_live   = sysref_edge && (state_q != ST_RESET);
    assign realign     = edge_live && !(cfg_sysref_oneshot && captured);

    assign beat_nat = beat_cnt + 5'd1;
    assign mb_nat   = (beat_cnt != 5'd31)         ? mb_cnt :
                      (mb_cnt == cfg_mb_per_emb)  ? '0     :
                                                    mb_cnt + EMB_WIDTH'(1);

    assign align_err = edge_live && (captured || cfg_sysref_disable) &&
                       ((beat_nat != cfg_lmc_offset) || (mb_nat != '0));

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_nat;
        mb_d    = mb_nat;

        case (state_q)
            ST_RESET:       state_d = cfg_sysref_disable ? ST_START : ST_WAIT_SYSREF;
            ST_WAIT_SYSREF: if (sysref_edge) state_d = ST_START;
            ST_START:       if (!realign && (beat_cnt == 5'd31) && (mb_cnt == cfg_mb_per_emb))
                                state_d = ST_DATA;
            ST_DATA:        state_d = ST_DATA;
            default:        state_d = ST_RESET;
        endcase

        if (state_q == ST_RESET) begin
            beat_d = '0;
            mb_d   = '0;
        end else if (realign) begin
            beat_d = cfg_lmc_offset;
            mb_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                      <= ST_RESET;
            beat_cnt                     <= '0;
            mb_cnt                       <= '0;
            sysref_d                     <= 1'b0;
            captured                     <= 1'b0;
            event_sysref_edge            <= 1'b0;
            event_sysref_alignment_error <= 1'b0;
        end else begin
            state_q                      <= state_d;
            beat_cnt                     <= beat_d;
            mb_cnt                       <= mb_d;
            sysref_d                     <= sysref;
            if (realign) captured        <= 1'b1;
            event_sysref_edge            <= edge_live;
            event_sysref_alignment_error <= align_err;
        end
    end

    // Frame-timing strobes stay quiet until the counters carry meaningful alignment.
    assign unmasked         = (state_q == ST_START) || (state_q == ST_DATA);
    assign lmc_edge         = unmasked && (beat_cnt == 5'd0);
    assign lmc_quarter_edge = unmasked && (beat_cnt[2:0] == 3'd0);
    assign eoemb            = unmasked && (mb_cnt == cfg_mb_per_emb);
    assign tx_ready         = (state_q == ST_DATA);
    assign status_state     = state_q;

endmodule

// File: tb/tb_jesd204_tx_ctrl_64b.sv
// Directed bench for jesd204_tx_ctrl_64b: free-run start, SYSREF alignment, periodic and
// misaligned SYSREF, one-shot mode, reset mid-DATA, single-multiblock EMB and START/SYSREF priority.
module tb_jesd204_tx_ctrl_64b;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sysref = 1'b0;
    logic [7:0] cfg_mb_per_emb = 8'd3;
    logic [4:0] cfg_lmc_offset = 5'd0;
    logic       cfg_sysref_oneshot = 1'b0;
    logic       cfg_sysref_disable = 1'b1;
    logic       tx_ready, lmc_edge, lmc_quarter_edge, eoemb;
    logic [1:0] status_state;
    logic       event_sysref_edge, event_sysref_alignment_error;

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;
    int t0    = 0;

    jesd204_tx_ctrl_64b #(.EMB_WIDTH(8)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .sysref                       (sysref),
        .cfg_mb_per_emb               (cfg_mb_per_emb),
        .cfg_lmc_offset               (cfg_lmc_offset),
        .cfg_sysref_oneshot           (cfg_sysref_oneshot),
        .cfg_sysref_disable           (cfg_sysref_disable),
        .tx_ready                     (tx_ready),
        .lmc_edge                     (lmc_edge),
        .lmc_quarter_edge             (lmc_quarter_edge),
        .eoemb                        (eoemb),
        .status_state                 (status_state),
        .event_sysref_edge            (event_sysref_edge),
        .event_sysref_alignment_error (event_sysref_alignment_error)
    );

    always #5 clk = ~clk;

    // Packed output vector: {tx_ready, lmc_edge, lmc_quarter_edge, eoemb, status_state[1:0], edge, err}
    function automatic logic [7:0] vec(input logic tx, input logic lmc, input logic q, input logic eo,
                                       input logic [1:0] st, input logic ev, input logic er);
        return {tx, lmc, q, eo, st, ev, er};
    endfunction

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {tx_ready, lmc_edge, lmc_quarter_edge, eoemb, status_state,
               event_sysref_edge, event_sysref_alignment_error};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @t=%0d: observed %b expected %b", tag, t - t0, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            t++;
        end
    endtask

    // Advance to observation point T+k relative to the last SYSREF reference t0.
    task automatic wait_to(input int k);
        if (t0 + k > t) step(t0 + k - t);
    endtask

    // Hold reset for n cycles checking outputs are zero, then release and step to the first post-reset cycle.
    task automatic hold_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            step(1);
            check("reset_hold", 8'h00);
        end
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        // Free-run start with SYSREF disabled, E-1 = 3
        hold_reset(3);
        t0 = t;
        for (int i = 0; i < 128; i++) begin
            check("dis_start", vec(1'b0, (i % 32) == 0, (i % 8) == 0, i >= 96, 2'd2, 1'b0, 1'b0));
            step(1);
        end
        for (int i = 0; i < 128; i++) begin
            check("dis_data", vec(1'b1, (i % 32) == 0, (i % 8) == 0, i >= 96, 2'd3, 1'b0, 1'b0));
            step(1);
        end

        // SYSREF alignment with offset 5, then periodic and early SYSREF
        reset = 1'b1;
        cfg_sysref_disable = 1'b0;
        cfg_lmc_offset     = 5'd5;
        hold_reset(1);
        check("wait_entry", vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0));
        step(9);
        check("wait_masked", vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0));
        t0 = t;
        sysref = 1'b1;
        wait_to(1);   check("align_t1", vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0));
        wait_to(2);   check("align_t2", vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0));
        sysref = 1'b0;
        wait_to(4);   check("align_quarter", vec(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0));
        wait_to(27);  check("align_pre_lmc", vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0));
        wait_to(28);  check("align_lmc", vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0));
        wait_to(123); check("start_last", vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0));
        wait_to(124); check("data_entry", vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        wait_to(128); check("per1_pre", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0));
        sysref = 1'b1;
        wait_to(129); check("per1_event", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0));
        sysref = 1'b0;
        wait_to(156); check("per1_lmc", vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        wait_to(256);
        sysref = 1'b1;
        wait_to(257); check("per2_event", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0));
        sysref = 1'b0;
        wait_to(381);
        sysref = 1'b1;
        wait_to(382); check("early_err", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1));
        sysref = 1'b0;
        wait_to(383); check("early_err_clr", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0));
        wait_to(409); check("early_realigned", vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        wait_to(412); check("early_old_gone", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0));

        // One-shot: misaligned second SYSREF flags but leaves counters alone
        reset = 1'b1;
        cfg_sysref_oneshot = 1'b1;
        hold_reset(1);
        t0 = t;
        sysref = 1'b1;
        wait_to(1);   check("os_align", vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0));
        sysref = 1'b0;
        wait_to(124); check("os_data", vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));
        wait_to(253);
        sysref = 1'b1;
        wait_to(254); check("os_err", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1));
        sysref = 1'b0;
        wait_to(281); check("os_not_moved", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0));
        wait_to(284); check("os_natural_lmc", vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0));

        // One-cycle reset mid-DATA with SYSREF rising in the same cycle
        reset  = 1'b1;
        sysref = 1'b1;
        step(1);      check("mid_reset", 8'h00);
        reset = 1'b0;
        step(1);      check("post_reset_wait", vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0));
        step(1);      check("post_reset_quiet", vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0));
        sysref = 1'b0;

        // Single-multiblock EMB, free-running
        reset = 1'b1;
        cfg_mb_per_emb     = 8'd0;
        cfg_sysref_oneshot = 1'b0;
        cfg_sysref_disable = 1'b1;
        hold_reset(1);
        t0 = t;
        check("e1_start", vec(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0));
        wait_to(31);  check("e1_last", vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0));
        wait_to(32);  check("e1_data", vec(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0));

        // SYSREF coinciding with the START->DATA condition keeps START
        reset = 1'b1;
        cfg_sysref_disable = 1'b0;
        hold_reset(1);
        t0 = t;
        sysref = 1'b1;
        wait_to(1);   check("prio_align", vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0));
        wait_to(2);
        sysref = 1'b0;
        wait_to(27);  check("prio_pre", vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0));
        sysref = 1'b1;
        wait_to(28);  check("prio_stay_start", vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1));
        sysref = 1'b0;
        wait_to(54);  check("prio_last", vec(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0));
        wait_to(55);  check("prio_data", vec(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
